// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: d = a - b - bi, LSB first, one full-subtractor cell
// plus a borrow flop, with a start/busy/done handshake.
module serial_subtractor #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bout,
    output logic         v
);

    localparam int unsigned CntW = (W > 2) ? $clog2(W) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t            r_state;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_res;
    logic              r_br;
    logic [CntW-1:0]   r_cnt;
    logic [W-1:0]      r_d;
    logic              r_bout;
    logic              r_v;

    logic              w_diff;
    logic              w_br_next;
    logic [W-1:0]      w_res_next;
    logic              w_last;

    always_comb begin
        w_diff     = r_a[0] ^ r_b[0] ^ r_br;
        w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
        w_res_next = {w_diff, r_res[W-1:1]};
        w_last     = (r_cnt == CntW'(W - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_v     <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_br    <= bi;
                        r_cnt   <= '0;
                        r_state <= StShift;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StShift: begin
                    r_res <= w_res_next;
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CntW'(1);
                    if (w_last) begin
                        // r_br here is the borrow into the MSB; results publish with done
                        r_d     <= w_res_next;
                        r_bout  <= w_br_next;
                        r_v     <= r_br ^ w_br_next;
                        r_state <= StDone;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        busy = (r_state == StShift);
        done = (r_state == StDone);
        d    = r_d;
        bout = r_bout;
        v    = r_v;
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (W=4) using immediate assertions.
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       bi;
    logic       busy;
    logic       done;
    logic [3:0] d;
    logic       bout;
    logic       v;

    int errors = 0;
    int checks = 0;
    int ndone;

    serial_subtractor #(.W(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bi    (bi),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [3:0] ia, input logic [3:0] ib,
                          input logic ibi, input logic [3:0] ed, input logic eb,
                          input logic ev);
        a = ia; b = ib; bi = ibi; start = 1'b1;
        step();
        start = 1'b0;
        a = ~ia; b = ~ib; bi = ~ibi;
        for (int i = 1; i <= 4; i++) begin
            chk({tag, " busy"}, {31'd0, busy}, 32'd1);
            chk({tag, " no-done"}, {31'd0, done}, 32'd0);
            step();
        end
        chk({tag, " done"}, {31'd0, done}, 32'd1);
        chk({tag, " busy-low"}, {31'd0, busy}, 32'd0);
        chk({tag, " d"}, {28'd0, d}, {28'd0, ed});
        chk({tag, " bout"}, {31'd0, bout}, {31'd0, eb});
        chk({tag, " v"}, {31'd0, v}, {31'd0, ev});
        step();
        chk({tag, " idle"}, {30'd0, busy, done}, 32'd0);
        chk({tag, " d-hold"}, {28'd0, d}, {28'd0, ed});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
        step();
        step();
        chk("reset outs", {25'd0, busy, done, d, bout, v}, 32'd0);
        rst = 1'b0;
        step();
        chk("idle stays", {31'd0, busy}, 32'd0);

        run_op("7-3",    4'd7,  4'd3, 1'b0, 4'd4,  1'b0, 1'b0);
        run_op("3-7",    4'd3,  4'd7, 1'b0, 4'd12, 1'b1, 1'b0);
        run_op("-8-1",   4'd8,  4'd1, 1'b0, 4'd7,  1'b0, 1'b1);
        run_op("0-0-1",  4'd0,  4'd0, 1'b1, 4'd15, 1'b1, 1'b0);

        // Held start: a result every 5 cycles, busy low only in done cycles
        a = 4'd6; b = 4'd6; bi = 1'b0; start = 1'b1;
        step();
        for (int k = 1; k <= 15; k++) begin
            chk("held done", {31'd0, done}, (k % 5 == 0) ? 32'd1 : 32'd0);
            chk("held busy", {31'd0, busy}, (k % 5 == 0) ? 32'd0 : 32'd1);
            if (k % 5 == 0) chk("held d", {27'd0, d, bout}, 32'd0);
            step();
        end
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
        chk("held drained", {30'd0, busy, done}, 32'd0);

        // Start during busy must be ignored
        a = 4'd5; b = 4'd1; bi = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        a = 4'd9; b = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            if (done) ndone++;
            step();
        end
        chk("ignored start ndone", ndone, 32'd1);
        chk("ignored start d", {28'd0, d}, 32'd4);
        chk("ignored start idle", {30'd0, busy, done}, 32'd0);

        // Reset in cycle 2 aborts the operation
        a = 4'd3; b = 4'd7; bi = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort outs", {25'd0, busy, done, d, bout, v}, 32'd0);
        ndone = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) ndone++;
            step();
        end
        chk("abort no done", ndone, 32'd0);
        chk("abort d stays 0", {28'd0, d}, 32'd0);

        run_op("10-4-1", 4'd10, 4'd4, 1'b1, 4'd5, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
